// File: rtl/riscv_types.sv
// Shared RISC-V pipeline types: the IF/ID register layout and the canonical NOP encoding.
package riscv_types;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [31:0] current_pc;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
  } if_id_reg_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF2 and ID: circular buffer that absorbs decode stalls and is
// discarded on redirect. in_ready depends only on registered occupancy, never on out_ready.
module if_fetch_queue
  import riscv_types::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = INST_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_pc4,
  input  logic [31:0]              in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output if_id_reg_t               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if_id_reg_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             enq;
  logic             deq;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // Empty queue presents a bubble so decode sees a harmless NOP instead of stale storage.
  assign out_data  = out_valid ? mem[rd_ptr] : '{current_pc: 32'h0, pc_plus_4: 32'h0, inst: NOP};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from count, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{current_pc: in_pc, pc_plus_4: in_pc4, inst: in_inst};
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a vector table for fill/drain plus hand-written
// sequences for streaming, flush, mid-operation reset and full-with-dequeue.
module tb_if_fetch_queue;
  import riscv_types::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_pc4, in_inst;
  logic        in_ready, out_valid;
  if_id_reg_t  out_data;
  logic [2:0]  count;

  int tests_run = 0;
  int tests_failed = 0;

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_pc4(in_pc4), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic [2:0]  cnt;
    logic        ov;
    logic        ir;
    logic [31:0] opc;
  } vec_t;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0033};
  endfunction

  task automatic check(input string name, input logic [95:0] actual, input logic [95:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] cnt, input logic ov,
                           input logic ir, input logic [31:0] opc);
    logic [95:0] exp_data;
    exp_data = ov ? {opc, opc + 32'd4, inst_of(opc)} : {32'h0, 32'h0, 32'h0000_0013};
    check({tag, ".count"},     96'(count),     96'(cnt));
    check({tag, ".out_valid"}, 96'(out_valid), 96'(ov));
    check({tag, ".in_ready"},  96'(in_ready),  96'(ir));
    check({tag, ".out_data"},  96'(out_data),  exp_data);
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc);
    in_valid = iv;
    in_pc    = pc;
    in_pc4   = pc + 32'd4;
    in_inst  = inst_of(pc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    // Fill to full with decode stalled, 5th offer ignored, then drain in order.
    vecs[0] = '{1'b1, 32'h00, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00};
    vecs[1] = '{1'b1, 32'h04, 1'b0, 3'd1, 1'b1, 1'b1, 32'h00};
    vecs[2] = '{1'b1, 32'h08, 1'b0, 3'd2, 1'b1, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 32'h0C, 1'b0, 3'd3, 1'b1, 1'b1, 32'h00};
    vecs[4] = '{1'b1, 32'h10, 1'b0, 3'd4, 1'b1, 1'b0, 32'h00};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 3'd4, 1'b1, 1'b0, 32'h00};
    vecs[6] = '{1'b0, 32'h00, 1'b1, 3'd3, 1'b1, 1'b1, 32'h04};
    vecs[7] = '{1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 1'b1, 32'h08};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0C};
    vecs[9] = '{1'b0, 32'h00, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    step(); step();
    reset = 1'b0;
    check_out("reset", 3'd0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].iv, vecs[i].pc);
      out_ready = vecs[i].ordy;
      check_out($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].ir, vecs[i].opc);
      step();
    end

    // Steady stream: one enq and one deq per cycle, occupancy pinned at 1 across pointer wraps.
    out_ready = 1'b1;
    drive(1'b1, 32'h100);
    check_out("stream0", 3'd0, 1'b0, 1'b1, 32'h0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(i < 10, 32'h100 + 32'(4 * i));
      check_out($sformatf("stream%0d", i), 3'd1, 1'b1, 1'b1, 32'h100 + 32'(4 * (i - 1)));
      step();
    end
    drive(1'b0, 32'h0);
    check_out("stream_end", 3'd0, 1'b0, 1'b1, 32'h0);

    // Flush with a wrong-path instruction offered in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(4 * i));
      step();
    end
    flush = 1'b1;
    drive(1'b1, 32'h200);
    check_out("flush_pre", 3'd3, 1'b1, 1'b1, 32'h180);
    step();
    flush = 1'b0;
    drive(1'b1, 32'h300);
    check_out("flush_post", 3'd0, 1'b0, 1'b1, 32'h0);
    step();
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    check_out("flush_next", 3'd1, 1'b1, 1'b1, 32'h300);
    step();
    check_out("flush_drained", 3'd0, 1'b0, 1'b1, 32'h0);

    // Reset while two entries are held; an offer during reset must not land.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i));
      step();
    end
    check_out("rst_pre", 3'd2, 1'b1, 1'b1, 32'h400);
    reset = 1'b1;
    drive(1'b1, 32'h408);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0);
    check_out("rst_post", 3'd0, 1'b0, 1'b1, 32'h0);
    step();
    check_out("rst_hold", 3'd0, 1'b0, 1'b1, 32'h0);

    // Full with both in_valid and out_ready: dequeue only, offered word is dropped.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      step();
    end
    check_out("full", 3'd4, 1'b1, 1'b0, 32'h500);
    drive(1'b1, 32'h510);
    out_ready = 1'b1;
    step();
    drive(1'b0, 32'h0);
    check_out("full_deq", 3'd3, 1'b1, 1'b1, 32'h504);
    step();
    check_out("full_d1", 3'd2, 1'b1, 1'b1, 32'h508);
    step();
    check_out("full_d2", 3'd1, 1'b1, 1'b1, 32'h50C);
    step();
    check_out("full_d3", 3'd0, 1'b0, 1'b1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
